// File: rtl/gpio_filt_pkg.sv
// Shared types and default sizes for the gpio input filter.
package gpio_filt_pkg;

    localparam int GPIO_FILT_PINS  = 8;
    localparam int GPIO_FILT_CNT_W = 16;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } type_gpio_filt_state_e;

endpackage

// File: rtl/gpio_filt_pin.sv
// One pin of the gpio input filter: pad synchroniser, debounce FSM with
// saturating stable-cycle counter, and registered rise/fall pulses.
// Optional build macro GPIO_FILT_SYNC3_EN selects a 3-flop synchroniser
// (one extra cycle of latency on every path); default is 2 flops.
import gpio_filt_pkg::*;

module gpio_filt_pin #(
    parameter int CNT_W = GPIO_FILT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pad_i,
    input  logic             filter_en_i,
    input  logic [CNT_W-1:0] debounce_len_i,
    output logic             pin_o,
    output logic             rise_o,
    output logic             fall_o
);

`ifdef GPIO_FILT_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [SYNC_N-1:0]     sync_q;
    logic                  cmp_s;
    type_gpio_filt_state_e state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pin_q, pin_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    // Resynchronise the asynchronous pad level; the last stage feeds the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_N{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], pad_i};
        end
    end

    assign cmp_s = sync_q[SYNC_N-1];

    // Debounce decision: flip the output once the synchronised level has
    // differed from it for debounce_len_i consecutive cycles (or at once in bypass).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pin_d   = pin_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE: begin
                cnt_d = CNT_ZERO;
                if (cmp_s == pin_q) begin
                    state_d = STABLE;
                end else if (!filter_en_i || (debounce_len_i == CNT_ZERO)) begin
                    pin_d  = ~pin_q;
                    rise_d = ~pin_q;
                    fall_d = pin_q;
                end else begin
                    state_d = CHECK;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK: begin
                if (cmp_s == pin_q) begin
                    // Bounced back before the window closed: discard the count.
                    state_d = STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (!filter_en_i || (cnt_q >= debounce_len_i)) begin
                    // Disabling the filter mid-count behaves as bypass.
                    state_d = STABLE;
                    cnt_d   = CNT_ZERO;
                    pin_d   = ~pin_q;
                    rise_d  = ~pin_q;
                    fall_d  = pin_q;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // FSM state, counter, filtered level and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= CNT_ZERO;
            pin_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pin_q   <= pin_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign pin_o  = pin_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_filter.sv
// Pad input conditioning for the gpio block: PINS independent copies of the
// per-pin synchroniser/debouncer sharing one debounce length.
// Optional build macro GPIO_FILT_SYNC3_EN (see gpio_filt_pin).
import gpio_filt_pkg::*;

module gpio_in_filter #(
    parameter int PINS  = GPIO_FILT_PINS,
    parameter int CNT_W = GPIO_FILT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PINS-1:0]  pad_i,
    input  logic [PINS-1:0]  filter_en_i,
    input  logic [CNT_W-1:0] debounce_len_i,
    output logic [PINS-1:0]  pin_o,
    output logic [PINS-1:0]  rise_o,
    output logic [PINS-1:0]  fall_o
);

    for (genvar g = 0; g < PINS; g++) begin : g_pin
        gpio_filt_pin #(
            .CNT_W (CNT_W)
        ) u_pin (
            .clk            (clk),
            .rst_n          (rst_n),
            .pad_i          (pad_i[g]),
            .filter_en_i    (filter_en_i[g]),
            .debounce_len_i (debounce_len_i),
            .pin_o          (pin_o[g]),
            .rise_o         (rise_o[g]),
            .fall_o         (fall_o[g])
        );
    end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// run-length reference model.
module tb_gpio_in_filter;

`ifdef GPIO_FILT_SYNC3_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 2;
`endif

    logic        clk;
    logic        rst_n = 1'b0;
    logic [7:0]  pad   = 8'h00;
    logic [7:0]  en    = 8'h00;
    logic [15:0] len   = 16'd0;
    logic [7:0]  pin_o, rise_o, fall_o;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_in_filter #(.PINS(8), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pad_i          (pad),
        .filter_en_i    (en),
        .debounce_len_i (len),
        .pin_o          (pin_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Output flips when the synchronised level differs from it and either the
    // filter is bypassed or it has already differed for >= len prior cycles.
    logic [7:0] hist [0:2];
    logic [7:0] m_pin, m_rise, m_fall;
    int         run [8];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) hist[k] = 8'h00;
                m_pin = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
                for (int i = 0; i < 8; i++) run[i] = 0;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    logic sv;
                    sv = hist[DLY-1][i];
                    m_rise[i] = 1'b0;
                    m_fall[i] = 1'b0;
                    if (sv != m_pin[i]) begin
                        if (!en[i] || len == 16'd0 || run[i] >= int'(len)) begin
                            m_pin[i]  = sv;
                            m_rise[i] = sv;
                            m_fall[i] = ~sv;
                            run[i]    = 0;
                        end else begin
                            run[i]++;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = pad;
            end
            #1;
            check("model", {8'h00, pin_o, rise_o, fall_o}, {8'h00, m_pin, m_rise, m_fall});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #12;
        check("reset_out", {8'h00, pin_o, rise_o, fall_o}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        wait_edges(4);

        // Bypass
        @(negedge clk); pad = 8'h01;
        wait_edges(DLY);     check("byp_pre",  {24'h0, pin_o}, 32'h00);
        wait_edges(1);       check("byp_pin",  {24'h0, pin_o}, 32'h01);
                             check("byp_rise", {24'h0, rise_o}, 32'h01);
        wait_edges(1);       check("byp_rise_end", {24'h0, rise_o}, 32'h00);
        @(negedge clk); pad = 8'h00;
        wait_edges(DLY + 1); check("byp_fall", {24'h0, fall_o}, 32'h01);
                             check("byp_pin0", {24'h0, pin_o}, 32'h00);

        // Debounce len=4 on pin 3
        @(negedge clk); en = 8'hFF; len = 16'd4;
        wait_edges(3);
        @(negedge clk); pad = 8'h08;
        wait_edges(DLY + 4); check("deb_early", {24'h0, pin_o}, 32'h00);
        wait_edges(1);       check("deb_pin",  {24'h0, pin_o}, 32'h08);
                             check("deb_rise", {24'h0, rise_o}, 32'h08);
        wait_edges(1);       check("deb_single", {24'h0, rise_o}, 32'h00);

        // Glitch reject on pin 5, ten times
        for (int r = 0; r < 10; r++) begin
            @(negedge clk); pad[5] = 1'b1;
            repeat (3) @(negedge clk);
            pad[5] = 1'b0;
            wait_edges(8);
            check("glitch", {31'h0, pin_o[5]}, 32'h0);
        end

        // Lowering len mid-count flips at the next edge
        @(negedge clk); len = 16'd100; pad[1] = 1'b1;
        wait_edges(52);      check("len_hold", {31'h0, pin_o[1]}, 32'h0);
        @(negedge clk); len = 16'd2;
        wait_edges(1);       check("len_drop", {30'h0, pin_o[1], rise_o[1]}, 32'h3);

        // Clearing filter_en mid-count acts as bypass
        @(negedge clk); len = 16'd100; pad[2] = 1'b1;
        wait_edges(10);      check("en_hold", {31'h0, pin_o[2]}, 32'h0);
        @(negedge clk); en[2] = 1'b0;
        wait_edges(1);       check("en_clear", {30'h0, pin_o[2], rise_o[2]}, 32'h3);
        @(negedge clk); en = 8'hFF;

        // Async reset mid-count, then release with pads high
        pad[4] = 1'b1;
        wait_edges(10);      check("pre_rst", {24'h0, pin_o}, 32'h0E);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;                  check("rst_async", {8'h00, pin_o, rise_o, fall_o}, 32'h0);
        pad = 8'hA5; len = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_edges(DLY);     check("rel_pre", {24'h0, pin_o}, 32'h00);
        wait_edges(1);       check("rel_pin", {24'h0, pin_o}, 32'hA5);
                             check("rel_rise", {24'h0, rise_o}, 32'hA5);

        // All pins toggle together with len=3
        @(negedge clk); len = 16'd3;
        wait_edges(2);
        @(negedge clk); pad = 8'h5A;
        wait_edges(DLY + 3); check("all_early", {24'h0, pin_o}, 32'hA5);
        wait_edges(1);       check("all_pin", {24'h0, pin_o}, 32'h5A);
                             check("all_rf", {16'h0, rise_o, fall_o}, 32'h5AA5);

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 7) == 0) pad[i] = ~pad[i];
            end
            if ($urandom_range(0, 150) == 0) len = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 250) == 0) en = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1500) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end
        end

        wait_edges(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Input-conditioning stage directly upstream of the gpio peripheral, between the pads and the gpio data/interrupt logic.
- Per pin: resynchronises the asynchronous pad level, applies a programmable debounce, and emits a clean level plus single-cycle rise/fall pulses.
- The gpio block samples pin_o instead of raw pads, so its interrupt-pending logic never sees metastable or bouncing inputs.

Parameters:
- PINS, 8, number of pins filtered.
- CNT_W, 16, width of the debounce counter and of debounce_len_i.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pad_i  input  PINS  raw pad levels, asynchronous to clk.
- filter_en_i  input  PINS  per-pin debounce enable; 0 = bypass (synchroniser only).
- debounce_len_i  input  CNT_W  stable cycles required before the output changes; shared by all pins; quasi-static.
- pin_o  output  PINS  filtered level; reset 0.
- rise_o  output  PINS  one-cycle pulse, high in the first cycle pin_o[i] reads 1; reset 0.
- fall_o  output  PINS  one-cycle pulse, high in the first cycle pin_o[i] reads 0; reset 0.

Behaviour:
- Reset: one clock, clk; reset asynchronous, active-low, rst_n. Assertion immediately clears synchroniser flops, FSMs (STABLE), counters, pin_o, rise_o and fall_o to 0, including mid-count; the in-progress count is discarded.
- Synchroniser: 2 flops per pin (s1, s2), reset 0.
  - Pad change stable before edge E0 → s1 at E0 → s2 at E1.
- Per-pin FSM states:
  - STABLE: counter = 0.
    - If s2 == pin_o, stay.
    - If s2 != pin_o and (filter_en = 0 or debounce_len_i = 0): flip pin_o at this edge, stay STABLE.
    - Otherwise: go to CHECK with cnt <= 1.
  - CHECK:
    - If s2 == pin_o (bounce back): go to STABLE, cnt <= 0, pin_o unchanged, no pulse.
    - Else if cnt >= debounce_len_i: flip pin_o, go to STABLE, cnt <= 0.
    - Else: cnt <= cnt + 1.
- Latency: pad change stable before E0 → pin_o changes at E(2+debounce_len_i); bypass/len = 0 → E2.
- A bounce shorter than debounce_len_i cycles at s2 produces no output change.
- Comparison is >=, so lowering debounce_len_i mid-count below cnt flips on the next edge.
- Counter saturates at 2^CNT_W-1 and never wraps. Unreachable with >= compare; required for safety.
- filter_en_i[i] cleared while in CHECK: next edge behaves as bypass (flip if s2 != pin_o), state to STABLE.
- Pulses: rise_o[i]/fall_o[i] are registered at the same edge pin_o flips. Each is high exactly one cycle; both are never high together on the same pin.
- Pads high at reset release: pin_o rises at E(2+len) after release, with a rise_o pulse. Intended; the gpio block sees it as a normal edge.
- Pins are fully independent. Simultaneous events on different pins are handled in the same cycle.

Optional Feature:
- Macro: GPIO_FILT_SYNC3_EN.
- Defined: synchroniser becomes 3 flops (s1, s2, s3); the FSM compares s3. All latencies increase by exactly 1 cycle (bypass E3, filtered E(3+len)).
- Undefined: 2-flop synchroniser as above.

Decomposition:
- Package gpio_filt_pkg:
  - type_gpio_filt_state_e {STABLE, CHECK}.
  - Constants GPIO_FILT_PINS = 8 and GPIO_FILT_CNT_W = 16, used as parameter defaults.
- Sub-module gpio_filt_pin: one pin's synchroniser, FSM, counter and pulse flops; inputs pad, filter_en, debounce_len.
- gpio_in_filter: generate loop instantiating PINS copies of gpio_filt_pin; no shared state beyond debounce_len_i.

Test Plan:
- Bypass: filter_en = 0, pad[0] 0→1 before E0 → pin_o[0] = 1 and rise_o[0] = 1 at E2, rise_o[0] = 0 at E3; pad 1→0 → fall_o[0] pulse at E2.
- Debounce: len = 4, filter_en = 0xFF, pad[3] steps 0→1 → pin_o[3] rises at E6; no change at E5; single rise_o pulse.
- Glitch reject: len = 4, pad[5] high for 3 cycles then low → pin_o[5] stays 0, no pulses. Repeated 10 times → still 0.
- Mid-count changes:
  - len reduced from 100 to 2 while cnt = 50 → pin_o flips on the next edge.
  - filter_en cleared mid-CHECK → flips on the next edge.
- Async reset mid-CHECK: assert rst_n low between edges → pin_o/rise_o/fall_o = 0 immediately. After release with pad = 0xA5 and len = 0 → pin_o = 0xA5 and rise_o = 0xA5 at E2.
- All 8 pins toggling on the same edge with len = 3 → all flip together at E5. Rerun with GPIO_FILT_SYNC3_EN → E6.
